// File: rtl/periph_lsu_if.sv
// Core-side request/response and peripheral-bus signals of periph_lsu, bundled for port connection.
interface periph_lsu_if #(
   parameter int ADDR_W = 8
);
   logic              req;
   logic              we_in;
   logic [2:0]        funct3;
   logic [31:0]       addr;
   logic [31:0]       wdata_in;
   logic              ready;
   logic [31:0]       rdata;
   logic              rvalid;
   logic              err;
   logic [ADDR_W-1:0] p_addr;
   logic [3:0]        p_be;
   logic [31:0]       p_wdata;
   logic              p_we;
   logic [31:0]       p_q;

   modport slave (
      input  req, we_in, funct3, addr, wdata_in, p_q,
      output ready, rdata, rvalid, err, p_addr, p_be, p_wdata, p_we
   );

   modport master (
      output req, we_in, funct3, addr, wdata_in, p_q,
      input  ready, rdata, rvalid, err, p_addr, p_be, p_wdata, p_we
   );
endinterface

// File: rtl/periph_lsu.sv
// RV32I load/store front-end onto a synchronous peripheral bus; one request at a time.
// Optional PLSU_ERR_CNT_EN adds a saturating err pulse counter (err_cnt) with synchronous clear (err_clr).
module periph_lsu #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
   parameter int          ADDR_W    = 8
) (
   input  logic         clk,
   input  logic         rst,
   periph_lsu_if.slave  bus
`ifdef PLSU_ERR_CNT_EN
   ,
   input  logic         err_clr,
   output logic [7:0]   err_cnt
`endif
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      RESP  = 3'd3,
      ERR   = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] p_addr_q, p_addr_d;
   logic [3:0]        p_be_q, p_be_d;
   logic [31:0]       p_wdata_q, p_wdata_d;
   logic              p_we_q, p_we_d;
   logic [1:0]        off_q, off_d;
   logic [2:0]        f3_q, f3_d;
   logic [31:0]       rdata_q, rdata_d;

   logic        illegal, out_of_win, misaligned;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   always_comb begin
      illegal    = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) ||
                   (bus.funct3 == 3'b111) || (bus.we_in && bus.funct3[2]);
      out_of_win = (bus.addr[31:8] != BASE_ADDR[31:8]);
      misaligned = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                   ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
   end

   // Byte enables and lane-replicated write data for the requested size.
   always_comb begin
      req_be    = 4'b1111;
      req_wdata = bus.wdata_in;
      case (bus.funct3[1:0])
         2'b00: begin
            req_be    = 4'b0001 << bus.addr[1:0];
            req_wdata = {4{bus.wdata_in[7:0]}};
         end
         2'b01: begin
            req_be    = 4'b0011 << {bus.addr[1], 1'b0};
            req_wdata = {2{bus.wdata_in[15:0]}};
         end
         default: begin
            req_be    = 4'b1111;
            req_wdata = bus.wdata_in;
         end
      endcase
   end

   always_comb begin
      ld_byte = bus.p_q[7:0];
      case (off_q)
         2'd0:    ld_byte = bus.p_q[7:0];
         2'd1:    ld_byte = bus.p_q[15:8];
         2'd2:    ld_byte = bus.p_q[23:16];
         default: ld_byte = bus.p_q[31:24];
      endcase
      ld_half = off_q[1] ? bus.p_q[31:16] : bus.p_q[15:0];
      case (f3_q)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_ext = {24'd0, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_ext = {16'd0, ld_half};
         default: ld_ext = bus.p_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      p_addr_d  = p_addr_q;
      p_be_d    = 4'd0;
      p_wdata_d = 32'd0;
      p_we_d    = 1'b0;
      off_d     = off_q;
      f3_d      = f3_q;
      rdata_d   = rdata_q;
      case (state_q)
         IDLE: begin
            if (bus.req) begin
               if (illegal || out_of_win || misaligned) begin
                  state_d = ERR;
               end else begin
                  state_d   = bus.we_in ? WRITE : READ;
                  p_addr_d  = ADDR_W'({bus.addr[7:2], 2'b00});
                  p_be_d    = req_be;
                  p_wdata_d = req_wdata;
                  p_we_d    = bus.we_in;
                  off_d     = bus.addr[1:0];
                  f3_d      = bus.funct3;
               end
            end
         end
         WRITE:   state_d = IDLE;
         READ:    state_d = RESP;
         RESP: begin
            state_d = IDLE;
            rdata_d = ld_ext;
         end
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         p_addr_q  <= '0;
         p_be_q    <= 4'd0;
         p_wdata_q <= 32'd0;
         p_we_q    <= 1'b0;
         off_q     <= 2'd0;
         f3_q      <= 3'd0;
         rdata_q   <= 32'd0;
      end else begin
         state_q   <= state_d;
         p_addr_q  <= p_addr_d;
         p_be_q    <= p_be_d;
         p_wdata_q <= p_wdata_d;
         p_we_q    <= p_we_d;
         off_q     <= off_d;
         f3_q      <= f3_d;
         rdata_q   <= rdata_d;
      end
   end

   // p_q is only valid during RESP, so rdata bypasses the holding register there.
   assign bus.rdata   = (state_q == RESP) ? ld_ext : rdata_q;
   assign bus.rvalid  = (state_q == RESP);
   assign bus.err     = (state_q == ERR);
   assign bus.ready   = (state_q == IDLE);
   assign bus.p_addr  = p_addr_q;
   assign bus.p_be    = p_be_q;
   assign bus.p_wdata = p_wdata_q;
   assign bus.p_we    = p_we_q;

`ifdef PLSU_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_clr) begin
         err_cnt_d = 8'd0;
      end else if ((state_q == ERR) && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q <= 8'd0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`else
   // Counter-free build: err pulses are not tallied.
`endif

endmodule

// File: tb/tb_periph_lsu.sv
// Directed bench for periph_lsu: acts as both the core and the peripheral.
module tb_periph_lsu;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   periph_lsu_if #(.ADDR_W(8)) bus_if ();

`ifdef PLSU_ERR_CNT_EN
   logic       err_clr;
   logic [7:0] err_cnt;
`endif

   periph_lsu #(
      .BASE_ADDR (32'h0000_1000),
      .ADDR_W    (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus_if)
`ifdef PLSU_ERR_CNT_EN
      ,
      .err_clr (err_clr),
      .err_cnt (err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic start(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
      @(negedge clk);
      bus_if.req      = 1'b1;
      bus_if.we_in    = we;
      bus_if.funct3   = f3;
      bus_if.addr     = a;
      bus_if.wdata_in = wd;
      @(posedge clk);
      #1 bus_if.req = 1'b0;
   endtask

   task automatic check_err_req(input string tag, input logic [2:0] f3, input logic [31:0] a);
      start(1'b0, f3, a, 32'd0);
      @(negedge clk);
      chk({tag, "_err"}, {31'd0, bus_if.err}, 32'd1);
      chk({tag, "_we"}, {31'd0, bus_if.p_we}, 32'd0);
      chk({tag, "_rv"}, {31'd0, bus_if.rvalid}, 32'd0);
      @(negedge clk);
      chk({tag, "_err_end"}, {31'd0, bus_if.err}, 32'd0);
      chk({tag, "_rdy"}, {31'd0, bus_if.ready}, 32'd1);
   endtask

   task automatic check_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] q, input logic [3:0] be, input logic [31:0] exp);
      bus_if.p_q = q;
      start(1'b0, f3, a, 32'd0);
      @(negedge clk);
      chk({tag, "_rd_be"}, {28'd0, bus_if.p_be}, {28'd0, be});
      chk({tag, "_rd_rv"}, {31'd0, bus_if.rvalid}, 32'd0);
      chk({tag, "_rd_we"}, {31'd0, bus_if.p_we}, 32'd0);
      @(negedge clk);
      chk({tag, "_rv"}, {31'd0, bus_if.rvalid}, 32'd1);
      chk({tag, "_rdata"}, bus_if.rdata, exp);
      @(negedge clk);
      chk({tag, "_rv_end"}, {31'd0, bus_if.rvalid}, 32'd0);
      chk({tag, "_rdy"}, {31'd0, bus_if.ready}, 32'd1);
      chk({tag, "_hold"}, bus_if.rdata, exp);
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      rst             = 1'b1;
      bus_if.req      = 1'b0;
      bus_if.we_in    = 1'b0;
      bus_if.funct3   = 3'd0;
      bus_if.addr     = 32'd0;
      bus_if.wdata_in = 32'd0;
      bus_if.p_q      = 32'd0;
`ifdef PLSU_ERR_CNT_EN
      err_clr = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", {31'd0, bus_if.ready}, 32'd1);
      chk("rst_p_addr", {24'd0, bus_if.p_addr}, 32'd0);
      chk("rst_p_be", {28'd0, bus_if.p_be}, 32'd0);
      chk("rst_p_wdata", bus_if.p_wdata, 32'd0);
      chk("rst_p_we", {31'd0, bus_if.p_we}, 32'd0);
      chk("rst_rdata", bus_if.rdata, 32'd0);
      chk("rst_rvalid", {31'd0, bus_if.rvalid}, 32'd0);
      chk("rst_err", {31'd0, bus_if.err}, 32'd0);

      // SW into the window
      start(1'b1, 3'b010, 32'h0000_1094, 32'h0050_8113);
      @(negedge clk);
      chk("sw_we", {31'd0, bus_if.p_we}, 32'd1);
      chk("sw_addr", {24'd0, bus_if.p_addr}, 32'h94);
      chk("sw_be", {28'd0, bus_if.p_be}, 32'hF);
      chk("sw_wdata", bus_if.p_wdata, 32'h0050_8113);
      chk("sw_busy", {31'd0, bus_if.ready}, 32'd0);
      @(negedge clk);
      chk("sw_we_end", {31'd0, bus_if.p_we}, 32'd0);
      chk("sw_ready", {31'd0, bus_if.ready}, 32'd1);
      chk("sw_be_end", {28'd0, bus_if.p_be}, 32'd0);
      chk("sw_wdata_end", bus_if.p_wdata, 32'd0);
      chk("sw_addr_hold", {24'd0, bus_if.p_addr}, 32'h94);

      // SB to the top byte of the window
      start(1'b1, 3'b000, 32'h0000_10FF, 32'h0000_00A5);
      @(negedge clk);
      chk("sb_we", {31'd0, bus_if.p_we}, 32'd1);
      chk("sb_addr", {24'd0, bus_if.p_addr}, 32'hFC);
      chk("sb_be", {28'd0, bus_if.p_be}, 32'h8);
      chk("sb_wdata", bus_if.p_wdata, 32'hA5A5_A5A5);
      @(negedge clk);
      chk("sb_ready", {31'd0, bus_if.ready}, 32'd1);

      // SH upper half
      start(1'b1, 3'b001, 32'h0000_1012, 32'hFFFF_BEEF);
      @(negedge clk);
      chk("sh_be", {28'd0, bus_if.p_be}, 32'hC);
      chk("sh_wdata", bus_if.p_wdata, 32'hBEEF_BEEF);
      chk("sh_addr", {24'd0, bus_if.p_addr}, 32'h10);
      @(negedge clk);

      check_load("lb",  3'b000, 32'h0000_1002, 32'h0080_0000, 4'b0100, 32'hFFFF_FF80);
      check_load("lbu", 3'b100, 32'h0000_1002, 32'h0080_0000, 4'b0100, 32'h0000_0080);
      check_load("lh",  3'b001, 32'h0000_1002, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
      check_load("lhu", 3'b101, 32'h0000_1002, 32'h8001_1234, 4'b1100, 32'h0000_8001);
      check_load("lh0", 3'b001, 32'h0000_1000, 32'h8001_7234, 4'b0011, 32'h0000_7234);
      check_load("lw",  3'b010, 32'h0000_1040, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

      check_err_req("lh_misal", 3'b001, 32'h0000_1003);
      check_err_req("f3_011",   3'b011, 32'h0000_1000);
      check_err_req("lw_oow",   3'b010, 32'h0000_2000);
      check_err_req("lw_misal", 3'b010, 32'h0000_1002);

      // Store with funct3[2]=1 is illegal
      start(1'b1, 3'b100, 32'h0000_1000, 32'h1);
      @(negedge clk);
      chk("sbu_err", {31'd0, bus_if.err}, 32'd1);
      chk("sbu_we", {31'd0, bus_if.p_we}, 32'd0);
      @(negedge clk);

      // Reset in the middle of a load aborts it silently
      bus_if.p_q = 32'h1234_5678;
      start(1'b0, 3'b010, 32'h0000_1008, 32'd0);
      @(negedge clk);
      chk("abort_in_read", {31'd0, bus_if.ready}, 32'd0);
      rst = 1'b1;
      #1;
      chk("abort_ready_async", {31'd0, bus_if.ready}, 32'd1);
      chk("abort_be_async", {28'd0, bus_if.p_be}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("abort_rvalid", {31'd0, bus_if.rvalid}, 32'd0);
      @(negedge clk);
      chk("abort_rvalid2", {31'd0, bus_if.rvalid}, 32'd0);
      chk("abort_ready", {31'd0, bus_if.ready}, 32'd1);
      chk("abort_err", {31'd0, bus_if.err}, 32'd0);

`ifdef PLSU_ERR_CNT_EN
      chk("cnt_rst", {24'd0, err_cnt}, 32'd0);
      for (int i = 0; i < 300; i++) begin
         start(1'b0, 3'b001, 32'h0000_1003, 32'd0);
         @(negedge clk);
         @(negedge clk);
         if (i == 4) chk("cnt_5", {24'd0, err_cnt}, 32'd5);
      end
      chk("cnt_sat", {24'd0, err_cnt}, 32'hFF);
      err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
      @(negedge clk);
      chk("cnt_clr", {24'd0, err_cnt}, 32'd0);
      start(1'b0, 3'b011, 32'h0000_1000, 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("cnt_one", {24'd0, err_cnt}, 32'd1);
      start(1'b0, 3'b011, 32'h0000_1000, 32'd0);
      @(negedge clk);
      chk("cnt_clr_err_vis", {31'd0, bus_if.err}, 32'd1);
      err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
      @(negedge clk);
      chk("cnt_clr_wins", {24'd0, err_cnt}, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/periph_lsu.md
Name: periph_lsu

Overview:
- Load/store front-end between the rysyCore pipeline and the memory-mapped peripheral bus. It sits directly upstream of the gpio peripheral.
- Accepts one RV32I load/store request at a time (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Decodes the peripheral address window and produces a registered addr/be/wdata/we bus cycle.
- For loads, captures the peripheral's q, then aligns and sign- or zero-extends it into the core's read data.

Parameters:
- BASE_ADDR, 32'h0000_1000: base of the 256-byte peripheral window. A request hits when addr[31:8] == BASE_ADDR[31:8].
- ADDR_W, 8: width of the peripheral address bus.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  core request strobe; sampled only when ready=1.
- we_in  input  1  1 = store, 0 = load.
- funct3  input  3  RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  input  32  byte address.
- wdata_in  input  32  store data; value in the low bits.
- ready  output  1  block idle; a request can be accepted.
- rdata  output  32  extended load result; valid only while rvalid=1.
- rvalid  output  1  one-cycle pulse: load data valid.
- err  output  1  one-cycle pulse: misaligned, illegal funct3, or out-of-window request.
- p_addr  output  ADDR_W  peripheral word address, equal to {addr[7:2],2'b00}.
- p_be  output  4  peripheral byte enables.
- p_wdata  output  32  peripheral write data, lane-replicated.
- p_we  output  1  peripheral write enable; one-cycle pulse.
- p_q  input  32  peripheral read data; valid in the cycle after p_addr is presented.

Behaviour:
- States: IDLE, WRITE, READ, RESP, ERR. ready = (state==IDLE).
- Reset state:
  - state = IDLE.
  - p_addr, p_be, p_wdata, p_we, rdata, rvalid, err all 0.
  - ready = 1.
- Reset mid-operation aborts the transaction. p_we drops asynchronously and no rvalid or err is issued.
- Acceptance: on a clk edge in IDLE with req=1, the request fields are registered.
  - Check precedence: illegal funct3 > out-of-window > misaligned. Any failure -> ERR.
  - Illegal funct3: 011, 110 or 111; for stores, also funct3[2]=1.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0] != 0.
  - Otherwise a store goes to WRITE and a load goes to READ.
- ERR: err=1 for exactly one cycle, then IDLE. No p_we, no rvalid.
- WRITE, one cycle:
  - p_we=1, p_addr valid.
  - Byte: p_be = 4'b0001 << addr[1:0]; p_wdata = {4{wdata_in[7:0]}}.
  - Half: p_be = 4'b0011 << {addr[1],1'b0}; p_wdata = {2{wdata_in[15:0]}}.
  - Word: p_be = 4'b1111; p_wdata = wdata_in.
  - Next state IDLE. Store occupancy is 1 busy cycle, so ready returns 2 edges after acceptance.
- READ, one cycle:
  - p_we=0; p_addr and p_be driven as for a store.
  - Next state RESP. p_q is sampled at the RESP edge.
- RESP: rvalid=1 for one cycle, then IDLE.
  - Byte lane = p_q >> (8*addr[1:0]).
  - LB sign-extends bit 7 and LBU zero-extends.
  - LH/LHU extend bit 15 of p_q >> (16*addr[1]).
  - LW passes p_q unmodified.
- Load latency: rvalid occurs 2 cycles after acceptance, and ready returns in the cycle after rvalid.
- req while ready=0 is ignored and not queued; the core must hold req until it is accepted.
- p_we, p_be and p_wdata return to 0 in every state other than WRITE/READ (p_be and p_wdata are also driven in READ). p_addr holds its last value.
- rdata holds its last value after rvalid falls.

Optional Feature:
- PLSU_ERR_CNT_EN
- Defined:
  - Adds output err_cnt[7:0], an 8-bit saturating count of err pulses.
  - Saturates at 8'hFF.
  - Reset to 0 by rst.
  - Adds input err_clr; err_clr=1 clears the count synchronously and wins over a simultaneous err.
- Not defined: no err_cnt or err_clr ports and no added logic. Behaviour is otherwise identical.

Test Plan:
- Reset, then idle: ready=1 and all p_* = 0. Assert rst mid-READ -> no rvalid, state IDLE, ready=1 after release.
- SW addr=0x0000_1094 wdata=0x00508113 -> WRITE cycle with p_addr=0x94, p_be=4'b1111, p_wdata=0x00508113, p_we=1 for exactly one cycle; ready back 2 edges after accept.
- SB addr=0x0000_10FF wdata=0x000000A5 -> p_addr=0xFC, p_be=4'b1000, p_wdata=0xA5A5A5A5.
- LB at 0x0000_1002 with p_q=0x0080_0000 -> rvalid 2 cycles after accept, rdata=0xFFFFFF80. LBU at the same address -> rdata=0x00000080.
- LH at 0x0000_1003 -> err one cycle, no p_we, no rvalid. funct3=011 -> err. LW at 0x0000_2000 (out of window) -> err.
- With PLSU_ERR_CNT_EN defined: 300 err requests -> err_cnt=0xFF. Pulse err_clr -> 0. err_clr together with err in the same cycle -> 0.
